// File: rtl/secuenciador_alu.sv
// secuenciador_alu: arithmetic sequencer between the command parser and the math units.
// Takes one request at a time, computes + and - locally, and dispatches *, / and s to the
// iterative units. The result and its error code are returned through a valid/accept
// handshake.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   sol_valida/sol_lista             request handshake (ready only in REPOSO)
//   sol_op, sol_a, sol_b             ASCII opcode and unsigned 16-bit operands
//   res_valido/res_aceptado          result handshake
//   res_dato, res_error              32-bit result; error 0 ok, 1 div/0, 2 bad op, 3 timeout
//   ocupado                          high outside REPOSO
//   op_a, op_b                       operands driven to the units
//   start_mult/div/raiz              registered one-cycle start pulses
//   fin_mult/div/raiz                unit done flags (level or pulse)
//   res_mult, res_div, res_raiz      unit results
//
// Optional feature: define SECUENCIADOR_ALU_WATCHDOG_EN to abort ESPERA after
// TIMEOUT_CICLOS cycles with error 3.
module secuenciador_alu #(
  parameter int unsigned TIMEOUT_CICLOS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sol_valida,
  output logic        sol_lista,
  input  logic [7:0]  sol_op,
  input  logic [15:0] sol_a,
  input  logic [15:0] sol_b,
  output logic        res_valido,
  input  logic        res_aceptado,
  output logic [31:0] res_dato,
  output logic [1:0]  res_error,
  output logic        ocupado,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        start_mult,
  output logic        start_div,
  output logic        start_raiz,
  input  logic        fin_mult,
  input  logic        fin_div,
  input  logic        fin_raiz,
  input  logic [31:0] res_mult,
  input  logic [31:0] res_div,
  input  logic [15:0] res_raiz
);

  localparam logic [7:0] OpSuma  = 8'h2B;  // '+'
  localparam logic [7:0] OpResta = 8'h2D;  // '-'
  localparam logic [7:0] OpMult  = 8'h2A;  // '*'
  localparam logic [7:0] OpDiv   = 8'h2F;  // '/'
  localparam logic [7:0] OpRaiz  = 8'h73;  // 's'

  typedef enum logic [2:0] {
    StReposo, StDespacho, StArranque, StEspera, StEntrega
  } estado_e;

  estado_e     estado_q, estado_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] res_dato_q, res_dato_d;
  logic [1:0]  res_error_q, res_error_d;
  logic        start_mult_q, start_mult_d;
  logic        start_div_q, start_div_d;
  logic        start_raiz_q, start_raiz_d;

  // Done flag and result of the unit that was actually dispatched; others are ignored.
  logic        fin_sel;
  logic [31:0] res_sel;

  always_comb begin
    fin_sel = 1'b0;
    res_sel = 32'd0;
    case (op_q)
      OpMult: begin fin_sel = fin_mult; res_sel = res_mult;             end
      OpDiv:  begin fin_sel = fin_div;  res_sel = res_div;              end
      OpRaiz: begin fin_sel = fin_raiz; res_sel = {16'd0, res_raiz};    end
      default: ;
    endcase
  end

`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CICLOS + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_expira;
  assign wd_expira = (wd_q == WdW'(TIMEOUT_CICLOS - 1));
`endif

  always_comb begin
    estado_d     = estado_q;
    op_d         = op_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_dato_d   = res_dato_q;
    res_error_d  = res_error_q;
    start_mult_d = 1'b0;
    start_div_d  = 1'b0;
    start_raiz_d = 1'b0;
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
    wd_d         = wd_q;
`endif
    unique case (estado_q)
      StReposo: begin
        if (sol_valida) begin
          op_d     = sol_op;
          op_a_d   = sol_a;
          op_b_d   = sol_b;
          estado_d = StDespacho;
        end
      end
      StDespacho: begin
        res_error_d = 2'd0;
        case (op_q)
          OpSuma: begin
            res_dato_d = {16'd0, op_a_q} + {16'd0, op_b_q};
            estado_d   = StEntrega;
          end
          OpResta: begin
            res_dato_d = {16'd0, op_a_q} - {16'd0, op_b_q};
            estado_d   = StEntrega;
          end
          OpMult: begin
            start_mult_d = 1'b1;
            estado_d     = StArranque;
          end
          OpRaiz: begin
            start_raiz_d = 1'b1;
            estado_d     = StArranque;
          end
          OpDiv: begin
            if (op_b_q != 16'd0) begin
              start_div_d = 1'b1;
              estado_d    = StArranque;
            end else begin
              res_dato_d  = 32'd0;
              res_error_d = 2'd1;
              estado_d    = StEntrega;
            end
          end
          default: begin
            res_dato_d  = 32'd0;
            res_error_d = 2'd2;
            estado_d    = StEntrega;
          end
        endcase
      end
      StArranque: begin
        // Guard cycle: a done flag still high from the previous operation is not taken.
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
        wd_d = '0;
`endif
        estado_d = StEspera;
      end
      StEspera: begin
        if (fin_sel) begin
          res_dato_d  = res_sel;
          res_error_d = 2'd0;
          estado_d    = StEntrega;
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
        end else if (wd_expira) begin
          res_dato_d  = 32'd0;
          res_error_d = 2'd3;
          estado_d    = StEntrega;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      StEntrega: begin
        if (res_aceptado) estado_d = StReposo;
      end
      default: estado_d = StReposo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= StReposo;
      op_q         <= 8'd0;
      op_a_q       <= 16'd0;
      op_b_q       <= 16'd0;
      res_dato_q   <= 32'd0;
      res_error_q  <= 2'd0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      start_raiz_q <= 1'b0;
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
      wd_q         <= '0;
`endif
    end else begin
      estado_q     <= estado_d;
      op_q         <= op_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_dato_q   <= res_dato_d;
      res_error_q  <= res_error_d;
      start_mult_q <= start_mult_d;
      start_div_q  <= start_div_d;
      start_raiz_q <= start_raiz_d;
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign sol_lista  = (estado_q == StReposo);
  assign ocupado    = (estado_q != StReposo);
  assign res_valido = (estado_q == StEntrega);
  assign res_dato   = res_dato_q;
  assign res_error  = res_error_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign start_mult = start_mult_q;
  assign start_div  = start_div_q;
  assign start_raiz = start_raiz_q;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Directed self-checking bench for secuenciador_alu. Unit done flags and results are driven
// by hand with the latencies the scenarios need. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point.
module tb_secuenciador_alu;

  logic        clk;
  logic        rst_n;
  logic        sol_valida;
  logic        sol_lista;
  logic [7:0]  sol_op;
  logic [15:0] sol_a, sol_b;
  logic        res_valido;
  logic        res_aceptado;
  logic [31:0] res_dato;
  logic [1:0]  res_error;
  logic        ocupado;
  logic [15:0] op_a, op_b;
  logic        start_mult, start_div, start_raiz;
  logic        fin_mult, fin_div, fin_raiz;
  logic [31:0] res_mult, res_div;
  logic [15:0] res_raiz;

  int n_total = 0;
  int n_bad   = 0;

  secuenciador_alu #(.TIMEOUT_CICLOS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sol_valida   (sol_valida),
    .sol_lista    (sol_lista),
    .sol_op       (sol_op),
    .sol_a        (sol_a),
    .sol_b        (sol_b),
    .res_valido   (res_valido),
    .res_aceptado (res_aceptado),
    .res_dato     (res_dato),
    .res_error    (res_error),
    .ocupado      (ocupado),
    .op_a         (op_a),
    .op_b         (op_b),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .start_raiz   (start_raiz),
    .fin_mult     (fin_mult),
    .fin_div      (fin_div),
    .fin_raiz     (fin_raiz),
    .res_mult     (res_mult),
    .res_div      (res_div),
    .res_raiz     (res_raiz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge (accept edge N); returns during cycle N+1.
  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    while (!sol_lista && guard < 100) begin
      step();
      guard++;
    end
    check("send_ready", {31'd0, sol_lista}, 32'd1);
    sol_valida = 1'b1;
    sol_op     = op;
    sol_a      = a;
    sol_b      = b;
    step();
    sol_valida = 1'b0;
  endtask

  task automatic accept(input string tag);
    res_aceptado = 1'b1;
    step();
    res_aceptado = 1'b0;
    check({tag, "_lista"}, {31'd0, sol_lista}, 32'd1);
    check({tag, "_valido_bajo"}, {31'd0, res_valido}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lista"},  {31'd0, sol_lista}, 32'd1);
    check({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    check({tag, "_valido"}, {31'd0, res_valido}, 32'd0);
    check({tag, "_dato"},   res_dato, 32'd0);
    check({tag, "_error"},  {30'd0, res_error}, 32'd0);
    check({tag, "_op_ab"},  {op_a, op_b}, 32'd0);
    check({tag, "_starts"}, {29'd0, start_mult, start_div, start_raiz}, 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; sol_valida = 1'b0; sol_op = 8'd0; sol_a = 16'd0; sol_b = 16'd0;
    res_aceptado = 1'b0; fin_mult = 1'b0; fin_div = 1'b0; fin_raiz = 1'b0;
    res_mult = 32'd0; res_div = 32'd0; res_raiz = 16'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    // Addition: result at N+2.
    send("+", 16'd1234, 16'd4321);
    check("suma_n1_valido", {31'd0, res_valido}, 32'd0);
    check("suma_n1_op_a", {16'd0, op_a}, 32'd1234);
    step();
    check("suma_valido", {31'd0, res_valido}, 32'd1);
    check("suma_dato", res_dato, 32'd5555);
    check("suma_error", {30'd0, res_error}, 32'd0);
    accept("suma");

    // Subtraction wraps.
    send("-", 16'd3, 16'd5);
    step();
    check("resta_dato", res_dato, 32'hFFFF_FFFE);
    check("resta_error", {30'd0, res_error}, 32'd0);
    accept("resta");

    // Multiplication, 17-cycle unit latency.
    send("*", 16'd300, 16'd200);
    check("mult_n1_start", {31'd0, start_mult}, 32'd0);
    step();
    check("mult_n2_start", {29'd0, start_mult, start_div, start_raiz}, 32'd4);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      cnt += int'(start_mult);
    end
    check("mult_un_solo_start", cnt, 32'd0);
    check("mult_espera_valido", {31'd0, res_valido}, 32'd0);
    fin_mult = 1'b1;
    res_mult = 32'd60000;
    step();
    fin_mult = 1'b0;
    check("mult_valido", {31'd0, res_valido}, 32'd1);
    check("mult_dato", res_dato, 32'd60000);
    check("mult_error", {30'd0, res_error}, 32'd0);
    accept("mult");

    // Division by zero: no start pulse.
    send("/", 16'd100, 16'd0);
    check("div0_n1_start", {31'd0, start_div}, 32'd0);
    step();
    check("div0_n2_start", {31'd0, start_div}, 32'd0);
    check("div0_valido", {31'd0, res_valido}, 32'd1);
    check("div0_dato", res_dato, 32'd0);
    check("div0_error", {30'd0, res_error}, 32'd1);
    accept("div0");

    // Invalid opcode.
    send("x", 16'd7, 16'd9);
    step();
    check("opx_valido", {31'd0, res_valido}, 32'd1);
    check("opx_error", {30'd0, res_error}, 32'd2);
    accept("opx");

    // Stale done: fin_raiz already high through ARRANQUE must not be taken.
    fin_raiz = 1'b1;
    res_raiz = 16'd99;
    send("s", 16'd144, 16'd0);
    step();
    check("raiz_start", {29'd0, start_mult, start_div, start_raiz}, 32'd1);
    step();
    check("raiz_guarda", {31'd0, res_valido}, 32'd0);
    fin_raiz = 1'b0;
    res_raiz = 16'd12;
    // Request and a foreign done during ESPERA are both ignored.
    sol_valida = 1'b1; sol_op = "+"; sol_a = 16'd1; sol_b = 16'd1;
    fin_div = 1'b1; res_div = 32'd77;
    step();
    sol_valida = 1'b0;
    fin_div = 1'b0;
    check("raiz_ajeno_valido", {31'd0, res_valido}, 32'd0);
    check("raiz_no_captura", {16'd0, op_a}, 32'd144);
    fin_raiz = 1'b1;
    step();
    fin_raiz = 1'b0;
    check("raiz_valido", {31'd0, res_valido}, 32'd1);
    check("raiz_dato", res_dato, 32'd12);
    check("raiz_error", {30'd0, res_error}, 32'd0);
    accept("raiz");
    check("raiz_sin_nueva_sol", {31'd0, ocupado}, 32'd0);

    // Division whose unit never answers.
    send("/", 16'd100, 16'd7);
    step();
    check("wd_start", {31'd0, start_div}, 32'd1);
`ifdef SECUENCIADOR_ALU_WATCHDOG_EN
    for (int i = 0; i < 64; i++) step();
    check("wd_antes", {31'd0, res_valido}, 32'd0);
    step();
    check("wd_valido", {31'd0, res_valido}, 32'd1);
    check("wd_dato", res_dato, 32'd0);
    check("wd_error", {30'd0, res_error}, 32'd3);
    accept("wd");
`else
    cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      cnt += int'(res_valido);
    end
    check("sin_wd_espera", cnt, 32'd0);
    check("sin_wd_ocupado", {31'd0, ocupado}, 32'd1);
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    step();
`endif

    // Reset in ESPERA of a multiplication.
    send("*", 16'd5, 16'd6);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_espera");
    @(negedge clk) rst_n = 1'b1;
    fin_mult = 1'b1;
    res_mult = 32'd30;
    step();
    step();
    fin_mult = 1'b0;
    check("rst_fin_tardio_valido", {31'd0, res_valido}, 32'd0);
    check("rst_fin_tardio_ocupado", {31'd0, ocupado}, 32'd0);
    send("+", 16'd2, 16'd2);
    step();
    check("rst_suma_dato", res_dato, 32'd4);
    check("rst_suma_error", {30'd0, res_error}, 32'd0);
    accept("rst_suma");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/secuenciador_alu.md
# secuenciador_alu

Sequencer that owns the calculator's arithmetic datapath: it accepts one operation request at a time from the command parser, computes addition and subtraction locally, and dispatches multiplication, division and square root to the iterative units `multiplicador`, `divisor` and `raiz`. It returns a 32-bit result with an error code through a valid/accept handshake. It sits between the UART command FSM and the math units, replacing ad-hoc start/done handling in the controller with one guarded, watchdog-protected sequence.

## Interface
- `TIMEOUT_CICLOS`, default 4096: cycles allowed in ESPERA before the watchdog aborts the operation.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sol_valida` in 1: request valid.
- `sol_lista` out 1: ready to accept. High only in REPOSO.
- `sol_op` in 8: ASCII opcode, one of `+` `-` `*` `/` `s`.
- `sol_a` in 16: operand A, unsigned.
- `sol_b` in 16: operand B, unsigned. Ignored for `s`.
- `res_valido` out 1: result valid.
- `res_aceptado` in 1: consumer takes the result.
- `res_dato` out 32: result.
- `res_error` out 2: 0 ok, 1 division by zero, 2 invalid opcode, 3 timeout.
- `ocupado` out 1: high in every state except REPOSO.
- `op_a`, `op_b` out 16 each: operands driven to the units.
- `start_mult`, `start_div`, `start_raiz` out 1 each: one-cycle start pulses.
- `fin_mult`, `fin_div`, `fin_raiz` in 1 each: unit done flags, level or pulse.
- `res_mult` in 32, `res_div` in 32, `res_raiz` in 16: unit results.

## Operation
- States: REPOSO, DESPACHO, ARRANQUE, ESPERA, ENTREGA.
- REPOSO:
  - On `sol_valida && sol_lista`, capture `sol_op`, `sol_a` and `sol_b`; `op_a`/`op_b` take the captured values; go to DESPACHO.
  - `sol_valida` while not in REPOSO is not captured. The requester holds it.
- DESPACHO:
  - `+`: `res_dato = {16'b0,a} + {16'b0,b}`; go to ENTREGA, error 0.
  - `-`: 32-bit two's-complement difference of the zero-extended operands. It wraps when b>a, e.g. 3-5 = 0xFFFFFFFE. Go to ENTREGA, error 0.
  - `*`: pulse `start_mult`; go to ARRANQUE.
  - `s`: pulse `start_raiz`; go to ARRANQUE.
  - `/` with b≠0: pulse `start_div`; go to ARRANQUE.
  - `/` with b=0: no start pulse; `res_dato` 0, error 1; go to ENTREGA.
  - Any other opcode: `res_dato` 0, error 2; go to ENTREGA.
- ARRANQUE:
  - One guard cycle. All `fin_*` are ignored so a stale done from the previous operation is never taken.
  - Go to ESPERA.
- ESPERA:
  - Sample only the `fin_*` of the dispatched unit.
  - When it is high, latch that unit's result into `res_dato`, error 0. `res_raiz` is zero-extended.
  - Go to ENTREGA.
- ENTREGA:
  - `res_valido` is high; `res_dato` and `res_error` are held stable.
  - On `res_aceptado`, go to REPOSO.
  - `res_aceptado` outside ENTREGA is ignored.
- Start pulses are registered and exactly one cycle wide. At most one is high in any cycle.
- `op_a`/`op_b` stay stable from capture until the next accept.
- `fin_*` arriving in REPOSO, or from a non-dispatched unit, is ignored.

## Timing
- Reset values, applied immediately on `rst_n` low:
  - state REPOSO, so `sol_lista` = 1 and `ocupado` = 0.
  - all start pulses 0, `res_valido` 0, `res_dato` 0, `res_error` 0, `op_a` 0, `op_b` 0.
- Reset mid-operation aborts without any further start pulse. Unit outputs arriving afterwards are ignored.
- Accept edge = cycle N:
  - DESPACHO during N+1.
  - For `+`, `-` and errors 1/2, `res_valido` is high from N+2.
  - For unit operations, the start pulse is high during N+2, ARRANQUE during N+2, and ESPERA from N+3.
  - A `fin` first seen in ESPERA at cycle M gives `res_valido` from M+1.
- `res_aceptado` seen at cycle K: `res_valido` is low and `sol_lista` high from K+1. The next accept is possible at K+1, giving one request per 3 cycles for `+`/`-`.

## Configuration
- `SECUENCIADOR_ALU_WATCHDOG_EN`:
  - When defined: a counter clears on entry to ESPERA and increments each ESPERA cycle. When it reaches `TIMEOUT_CICLOS` without `fin`, go to ENTREGA with `res_dato` 0 and error 3. A `fin` in the same cycle as expiry wins, error 0.
  - When undefined: there is no counter, ESPERA waits indefinitely, and error 3 is never produced.

## Test plan
- Reset then `+`, a=1234, b=4321: `res_valido` at N+2, `res_dato` = 5555, error 0. After `res_aceptado`, `sol_lista` is 1 the next cycle.
- `-`, a=3, b=5: `res_dato` = 0xFFFFFFFE. `*`, a=300, b=200, unit model with 17-cycle latency: exactly one `start_mult` at N+2, `res_dato` = 60000.
- `/`, a=100, b=0: no `start_div`, `res_dato` 0, error 1. Opcode `x`: error 2.
- Stale-done check: `fin_raiz` held high from the previous operation during ARRANQUE, then `s` with a=144: result is taken only from the new `fin`, `res_dato` = 12. `sol_valida` pulsed during ESPERA is not captured.
- Watchdog (macro on, `TIMEOUT_CICLOS`=64): `fin_div` never asserts, so error 3 and `res_dato` 0 after 64 ESPERA cycles. With the macro off, `res_valido` stays 0 for 10000 cycles.
- `rst_n` low during ESPERA of `*`: all outputs return to their reset values immediately. A late `fin_mult` after reset is ignored, and a following `+` 2+2 returns 4.
